// File: rtl/usrt_apb_pkg.sv
// Shared types and defaults for the USRT APB scheduler slice.
package usrt_apb_pkg;

   localparam int DATA_W                 = 8;
   localparam int DEFAULT_TIMEOUT_CYCLES = 1040;
   localparam int DEFAULT_ADDR_W         = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: the requester at the pointer wins ties,
// and after each accepted grant the pointer moves to the other requester.
module rr_arbiter2 (
   input  logic       pClk,
   input  logic       pReset,
   input  logic [1:0] i_req,
   input  logic       i_advance,
   output logic [1:0] o_grant
);

   logic       r_ptr;
   logic [1:0] w_grant;

   // Pick the requester at the pointer if it is asking, otherwise the other one
   always_comb begin
      w_grant = 2'b00;
      if (r_ptr == 1'b0) begin
         if (i_req[0])      w_grant = 2'b01;
         else if (i_req[1]) w_grant = 2'b10;
      end else begin
         if (i_req[1])      w_grant = 2'b10;
         else if (i_req[0]) w_grant = 2'b01;
      end
   end

   // Hand priority to the requester that lost (or did not ask) on every accepted grant
   always_ff @(posedge pClk or posedge pReset) begin
      if (pReset) begin
         r_ptr <= 1'b0;
      end else if (i_advance && (w_grant != 2'b00)) begin
         r_ptr <= w_grant[0];
      end
   end

   assign o_grant = w_grant;

endmodule

// File: rtl/usrt_apb_scheduler.sv
// Arbitrates two byte requesters onto a single APB master port that talks to
// a USRT slave; one transfer in flight, with an ACCESS-phase timeout.
module usrt_apb_scheduler
   import usrt_apb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int ADDR_W         = DEFAULT_ADDR_W
) (
   input  logic              pClk,
   input  logic              pReset,

   input  logic              req0_valid,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,

   input  logic              req1_valid,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,

   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   output logic              rsp0_err,

   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              rsp1_err,

   output logic              m_pSelect,
   output logic              m_pEnable,
   output logic              m_pWrite,
   output logic [ADDR_W-1:0] m_pAddress,
   output logic [DATA_W-1:0] m_pWData,
   input  logic [DATA_W-1:0] m_pRData,
   input  logic              m_pReady
);

   localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            r_state;
   state_t            w_nextState;
   logic              r_gntIdx;
   logic              r_write;
   logic              r_err;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic [CNT_W-1:0]  r_cnt;

   logic [1:0]        w_req;
   logic [1:0]        w_grant;
   logic              w_accept;
   logic              w_timeout;

   assign w_req = {req1_valid, req0_valid};

   rr_arbiter2 u_arbiter (
      .pClk      (pClk),
      .pReset    (pReset),
      .i_req     (w_req),
      .i_advance (w_accept),
      .o_grant   (w_grant)
   );

   // State register; reset drops any transfer in flight
   always_ff @(posedge pClk or posedge pReset) begin
      if (pReset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state plus every output; the bus is only driven in SETUP/ACCESS
   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      w_timeout   = 1'b0;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      rsp0_valid  = 1'b0;
      rsp0_rdata  = '0;
      rsp0_err    = 1'b0;
      rsp1_valid  = 1'b0;
      rsp1_rdata  = '0;
      rsp1_err    = 1'b0;
      m_pSelect   = 1'b0;
      m_pEnable   = 1'b0;
      m_pWrite    = 1'b0;
      m_pAddress  = '0;
      m_pWData    = '0;
      case (r_state)
         IDLE: begin
            if ((w_req != 2'b00) && !pReset) begin
               w_accept    = 1'b1;
               req0_ready  = w_grant[0];
               req1_ready  = w_grant[1];
               w_nextState = SETUP;
            end
         end
         SETUP: begin
            m_pSelect   = 1'b1;
            m_pWrite    = r_write;
            m_pAddress  = r_addr;
            m_pWData    = r_wdata;
            w_nextState = ACCESS;
         end
         ACCESS: begin
            m_pSelect  = 1'b1;
            m_pEnable  = 1'b1;
            m_pWrite   = r_write;
            m_pAddress = r_addr;
            m_pWData   = r_wdata;
            if (m_pReady) begin
               w_nextState = RESP;
            end else if (r_cnt == CNT_LAST) begin
               w_timeout   = 1'b1;
               w_nextState = RESP;
            end
         end
         RESP: begin
            if (r_gntIdx) begin
               rsp1_valid = 1'b1;
               rsp1_rdata = r_rdata;
               rsp1_err   = r_err;
            end else begin
               rsp0_valid = 1'b1;
               rsp0_rdata = r_rdata;
               rsp0_err   = r_err;
            end
            w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Capture the granted request and the slave's answer for the response phase
   always_ff @(posedge pClk or posedge pReset) begin
      if (pReset) begin
         r_gntIdx <= 1'b0;
         r_write  <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_gntIdx <= w_grant[1];
            r_write  <= w_grant[1] ? req1_write : req0_write;
            r_addr   <= w_grant[1] ? req1_addr  : req0_addr;
            r_wdata  <= w_grant[1] ? req1_wdata : req0_wdata;
            r_rdata  <= '0;
            r_err    <= 1'b0;
         end
         if (r_state == ACCESS) begin
            if (m_pReady) begin
               if (!r_write) begin
                  r_rdata <= m_pRData;
               end
            end else if (w_timeout) begin
               r_err <= 1'b1;
            end
         end
      end
   end

   // Count ACCESS cycles spent waiting on the slave; zero everywhere else
   always_ff @(posedge pClk or posedge pReset) begin
      if (pReset) begin
         r_cnt <= '0;
      end else if ((r_state == ACCESS) && !m_pReady && !w_timeout) begin
         r_cnt <= r_cnt + 1'b1;
      end else begin
         r_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_usrt_apb_scheduler.sv
// Directed bench for usrt_apb_scheduler with a response scoreboard.
module tb_usrt_apb_scheduler;
   import usrt_apb_pkg::*;

   localparam int AW = DEFAULT_ADDR_W;
   localparam int TO = DEFAULT_TIMEOUT_CYCLES;

   typedef struct {
      int         idx;
      logic [7:0] rdata;
      logic       err;
   } expect_t;

   logic          pClk;
   logic          pReset;
   logic          req0Valid, req0Write, req0Ready;
   logic [AW-1:0] req0Addr;
   logic [7:0]    req0Wdata;
   logic          req1Valid, req1Write, req1Ready;
   logic [AW-1:0] req1Addr;
   logic [7:0]    req1Wdata;
   logic          rsp0Valid, rsp0Err, rsp1Valid, rsp1Err;
   logic [7:0]    rsp0Rdata, rsp1Rdata;
   logic          mSelect, mEnable, mWrite, mReady;
   logic [AW-1:0] mAddress;
   logic [7:0]    mWData, mRData;

   expect_t sbQueue[$];
   int      total;
   int      bad;
   int      cycle;

   usrt_apb_scheduler #(
      .TIMEOUT_CYCLES (TO),
      .ADDR_W         (AW)
   ) dut (
      .pClk       (pClk),
      .pReset     (pReset),
      .req0_valid (req0Valid),
      .req0_write (req0Write),
      .req0_addr  (req0Addr),
      .req0_wdata (req0Wdata),
      .req0_ready (req0Ready),
      .req1_valid (req1Valid),
      .req1_write (req1Write),
      .req1_addr  (req1Addr),
      .req1_wdata (req1Wdata),
      .req1_ready (req1Ready),
      .rsp0_valid (rsp0Valid),
      .rsp0_rdata (rsp0Rdata),
      .rsp0_err   (rsp0Err),
      .rsp1_valid (rsp1Valid),
      .rsp1_rdata (rsp1Rdata),
      .rsp1_err   (rsp1Err),
      .m_pSelect  (mSelect),
      .m_pEnable  (mEnable),
      .m_pWrite   (mWrite),
      .m_pAddress (mAddress),
      .m_pWData   (mWData),
      .m_pRData   (mRData),
      .m_pReady   (mReady)
   );

   // Free-running 100 MHz clock
   initial begin
      pClk = 1'b0;
      forever #5 pClk = ~pClk;
   end

   task automatic tick();
      @(posedge pClk);
      #1;
      cycle++;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int n, input logic v, input logic w, input logic [AW-1:0] a, input logic [7:0] d);
      if (n == 0) begin
         req0Valid = v; req0Write = w; req0Addr = a; req0Wdata = d;
      end else begin
         req1Valid = v; req1Write = w; req1Addr = a; req1Wdata = d;
      end
   endtask

   task automatic pushExpect(input int who, input logic [7:0] rdata, input logic err);
      expect_t e;
      e.idx   = who;
      e.rdata = rdata;
      e.err   = err;
      sbQueue.push_back(e);
   endtask

   // Returns 0 or 1 for the requester whose ready pulses, -1 if none within the budget
   task automatic waitGrant(output int who);
      who = -1;
      #1;
      for (int n = 0; n < 40; n++) begin
         if (req0Ready === 1'b1) begin who = 0; break; end
         if (req1Ready === 1'b1) begin who = 1; break; end
         tick();
      end
      checkOutput("singleReady", {1'b0, req0Ready & req1Ready}, 64'd0);
   endtask

   // Plays the slave from the grant cycle until the response cycle
   task automatic serviceTransfer(input int readyAfter, input logic [7:0] slaveData,
                                  input logic [AW-1:0] expAddr, input logic expWrite,
                                  input logic [7:0] expWdata, input logic dropValid,
                                  output int enCycles, output int latency);
      latency  = 0;
      enCycles = 0;
      tick(); latency++;
      if (dropValid) begin
         req0Valid = 1'b0;
         req1Valid = 1'b0;
      end
      checkOutput("setupSelect", mSelect, 1);
      checkOutput("setupEnable", mEnable, 0);
      checkOutput("setupAddr", mAddress, expAddr);
      checkOutput("setupWrite", mWrite, expWrite);
      checkOutput("setupWData", mWData, expWdata);
      checkOutput("setupNoReady", {req0Ready, req1Ready}, 0);
      tick(); latency++;
      while (mEnable === 1'b1 && enCycles < TO + 8) begin
         enCycles++;
         if (enCycles == 1) begin
            checkOutput("accessAddr", mAddress, expAddr);
            checkOutput("accessWData", mWData, expWdata);
         end
         if (readyAfter != 0 && enCycles == readyAfter) begin
            mReady = 1'b1;
            mRData = slaveData;
         end else begin
            mReady = 1'b0;
            mRData = 8'hA5;
         end
         tick(); latency++;
      end
      mReady = 1'b0;
      mRData = 8'hA5;
   endtask

   // At the response cycle: pop the scoreboard and compare, then confirm the pulse ends
   task automatic checkResponse();
      expect_t e;
      checkOutput("sbDepth", sbQueue.size(), 1);
      if (sbQueue.size() > 0) begin
         e = sbQueue.pop_front();
      end else begin
         e.idx = -1; e.rdata = 8'h00; e.err = 1'b0;
      end
      checkOutput("rsp0Valid", rsp0Valid, (e.idx == 0));
      checkOutput("rsp1Valid", rsp1Valid, (e.idx == 1));
      checkOutput("rspRdata", (e.idx == 1) ? rsp1Rdata : rsp0Rdata, e.rdata);
      checkOutput("rspErr", (e.idx == 1) ? rsp1Err : rsp0Err, e.err);
      checkOutput("respBusIdle", {mSelect, mEnable, mWrite, mAddress, mWData}, 0);
      tick();
      checkOutput("rspPulseEnds", {rsp0Valid, rsp1Valid}, 0);
   endtask

   initial begin
      int who;
      int enCycles;
      int latency;
      int lastGrant;
      total = 0; bad = 0; cycle = 0; lastGrant = 0;
      pReset = 1'b1;
      mReady = 1'b0;
      mRData = 8'hA5;
      applyStimulus(0, 1'b0, 1'b0, '0, 8'h00);
      applyStimulus(1, 1'b0, 1'b0, '0, 8'h00);
      repeat (2) tick();

      // Reset holds every output low even with a request waiting
      applyStimulus(0, 1'b1, 1'b1, 32'h0000_0000, 8'hF0);
      #1;
      checkOutput("resetReady0", req0Ready, 0);
      checkOutput("resetBus", {mSelect, mEnable, mWrite, mAddress, mWData}, 0);
      checkOutput("resetRsp", {rsp0Valid, rsp1Valid}, 0);
      tick();
      pReset = 1'b0;

      // Req0 write, slave ready on first ACCESS cycle
      waitGrant(who);
      checkOutput("t1Grant", who, 0);
      pushExpect(0, 8'h00, 1'b0);
      serviceTransfer(1, 8'h3C, 32'h0000_0000, 1'b1, 8'hF0, 1'b1, enCycles, latency);
      checkOutput("t1EnCycles", enCycles, 1);
      checkOutput("t1Latency", latency, 3);
      checkResponse();

      // Req1 read, slave answers 0x8E on the 10th ACCESS cycle
      applyStimulus(1, 1'b1, 1'b0, 32'h1000_0004, 8'h77);
      waitGrant(who);
      checkOutput("t2Grant", who, 1);
      pushExpect(1, 8'h8E, 1'b0);
      serviceTransfer(10, 8'h8E, 32'h1000_0004, 1'b0, 8'h77, 1'b1, enCycles, latency);
      checkOutput("t2EnCycles", enCycles, 10);
      checkResponse();

      // Both requesters held valid: grants must alternate starting from 0
      applyStimulus(0, 1'b1, 1'b1, 32'h0000_0020, 8'h11);
      applyStimulus(1, 1'b1, 1'b0, 32'h0000_0024, 8'h00);
      for (int k = 0; k < 4; k++) begin
         waitGrant(who);
         checkOutput($sformatf("t3Grant%0d", k), who, k % 2);
         if (k > 0) checkOutput($sformatf("t3Spacing%0d", k), cycle - lastGrant, 4);
         lastGrant = cycle;
         if (who == 1) begin
            pushExpect(1, 8'h3C, 1'b0);
            serviceTransfer(1, 8'h3C, 32'h0000_0024, 1'b0, 8'h00, 1'b0, enCycles, latency);
         end else begin
            pushExpect(0, 8'h00, 1'b0);
            serviceTransfer(1, 8'h3C, 32'h0000_0020, 1'b1, 8'h11, 1'b0, enCycles, latency);
         end
         checkResponse();
      end
      applyStimulus(0, 1'b0, 1'b0, '0, 8'h00);
      applyStimulus(1, 1'b0, 1'b0, '0, 8'h00);

      // Slave never ready: timeout after the full ACCESS budget
      applyStimulus(0, 1'b1, 1'b0, 32'h0000_0030, 8'h00);
      waitGrant(who);
      checkOutput("t4Grant", who, 0);
      pushExpect(0, 8'h00, 1'b1);
      serviceTransfer(0, 8'h00, 32'h0000_0030, 1'b0, 8'h00, 1'b1, enCycles, latency);
      checkOutput("t4EnCycles", enCycles, TO);
      checkResponse();

      // Reset in the middle of ACCESS drops the transfer and the pointer
      applyStimulus(0, 1'b1, 1'b1, 32'h0000_0040, 8'h55);
      waitGrant(who);
      checkOutput("t5Grant", who, 0);
      tick();
      applyStimulus(0, 1'b0, 1'b0, '0, 8'h00);
      tick();
      checkOutput("t5InAccess", mEnable, 1);
      #2;
      pReset = 1'b1;
      #1;
      checkOutput("t5AsyncSelect", mSelect, 0);
      checkOutput("t5AsyncEnable", mEnable, 0);
      tick();
      pReset = 1'b0;
      sbQueue.delete();
      for (int k = 0; k < 6; k++) begin
         tick();
         checkOutput("t5NoRsp", {rsp0Valid, rsp1Valid}, 0);
      end
      applyStimulus(0, 1'b1, 1'b1, 32'h0000_0050, 8'hAA);
      applyStimulus(1, 1'b1, 1'b0, 32'h0000_0054, 8'h00);
      waitGrant(who);
      checkOutput("t5PostResetGrant", who, 0);
      pushExpect(0, 8'h00, 1'b0);
      serviceTransfer(1, 8'h3C, 32'h0000_0050, 1'b1, 8'hAA, 1'b1, enCycles, latency);
      checkResponse();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/usrt_apb_scheduler.md
USRT_APB_SCHEDULER -- requirements
Module: usrt_apb_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1040, maximum ACCESS cycles waited for m_pReady (one 13-bit USRT frame at 80 clocks/bit).
REQ-002 Parameter ADDR_W, default 32, APB address width.
REQ-003 pClk  input  1  single clock; all state changes on rising edge.
REQ-004 pReset  input  1  asynchronous, active-high reset.
REQ-005 reqN_valid  input  1  (N=0,1) requester N has a pending transfer.
REQ-006 reqN_write  input  1  1 = write byte to USRT, 0 = read byte from USRT.
REQ-007 reqN_addr  input  ADDR_W  APB target address.
REQ-008 reqN_wdata  input  8  write byte.
REQ-009 reqN_ready  output  1  one-cycle pulse: request N accepted.
REQ-010 rspN_valid  output  1  one-cycle pulse: transfer for N completed.
REQ-011 rspN_rdata  output  8  read byte, valid with rspN_valid.
REQ-012 rspN_err  output  1  timeout flag, valid with rspN_valid.
REQ-013 m_pSelect, m_pEnable, m_pWrite  output  1 each  APB master controls to the USRT slave.
REQ-014 m_pAddress  output  ADDR_W; m_pWData  output  8; m_pRData  input  8; m_pReady  input  1.

Function
REQ-015 FSM states: IDLE, SETUP, ACCESS, RESP; exactly one transfer in flight.
REQ-016 IDLE: if any reqN_valid, grant one requester, latch its write/addr/wdata, pulse reqN_ready in that cycle, next state SETUP.
REQ-017 Arbitration: round-robin over two requesters; priority pointer starts at 0 and moves to the non-granted requester after each grant.
REQ-018 Both valid simultaneously: only the requester at the priority pointer is granted; the other stays pending, no reqN_ready.
REQ-019 SETUP (one cycle): m_pSelect=1, m_pEnable=0, address/write/wdata driven from latches; m_pReady ignored; next state ACCESS.
REQ-020 ACCESS: m_pSelect=1, m_pEnable=1; on m_pReady=1, capture m_pRData (reads only), next state RESP.
REQ-021 ACCESS timeout counter starts at 0 on entry and increments each cycle without m_pReady; at count TIMEOUT_CYCLES-1 without m_pReady, go RESP with error set.
REQ-022 RESP (one cycle): m_pSelect=m_pEnable=0; pulse rspN_valid for the granted N with rdata/err; next state IDLE.
REQ-023 rspN_rdata = 0 on writes and on timeout; rspN_err = 0 on normal completion.
REQ-024 Latency: m_pReady high on first ACCESS cycle gives rspN_valid 3 cycles after the reqN_ready cycle; minimum spacing between acceptances 4 cycles.
REQ-025 Address, m_pWrite, m_pWData stay constant from SETUP through ACCESS; driven 0 in IDLE and RESP.
REQ-026 reqN_valid deasserted after acceptance has no effect on the in-flight transfer.

Reset
REQ-027 pReset high asynchronously forces IDLE, priority pointer 0, counter 0, all outputs 0.
REQ-028 Reset during SETUP/ACCESS drops the transfer: no rspN_valid is ever produced for it.
REQ-029 First grant is possible on the first rising edge after pReset deasserts.

Structure
REQ-030 Package usrt_apb_pkg holds the state enumeration, default TIMEOUT_CYCLES, data width 8 and default ADDR_W.
REQ-031 Sub-module rr_arbiter2 (two-way round-robin grant with pointer update) is instantiated once; FSM, latches and counter stay in the top.
REQ-032 Timeout counter width is clog2(TIMEOUT_CYCLES).

Verification
REQ-033 Req0 write addr 0x0, wdata 0xF0, m_pReady high on first ACCESS -> SETUP/ACCESS one cycle each with m_pWData=0xF0; rsp0_valid 3 cycles after req0_ready, err=0.
REQ-034 Req1 read, slave returns 0x8E after 10 ACCESS cycles -> rsp1_rdata=0x8E, err=0, m_pEnable high exactly 10 cycles.
REQ-035 Both valid continuously for 4 transfers -> grants 0,1,0,1; no overlap of SETUP/ACCESS.
REQ-036 m_pReady held low -> m_pEnable high exactly 1040 cycles, then rsp0_valid with err=1, rdata=0x00.
REQ-037 pReset pulsed during ACCESS -> m_pSelect/m_pEnable low asynchronously, no rsp pulse, next request granted to requester 0.
